fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO. Lives entirely in the read clock domain.
- Drains FIFO entries through the rempty/rinc/rdata interface and packs RATIO consecutive DSIZE-bit entries into one wide word.
- Presents packed words downstream on a valid/ready stream.
- Supports a flush request that emits a partially filled word with a lane-keep mask.

Parameters:
- DSIZE, 8, width of one FIFO entry (must match the FIFO's DSIZE).
- RATIO, 4, FIFO entries per output word; legal range 2..16.

Ports:
- rclk  input  1  read-domain clock; all logic is on its rising edge.
- rrst_n  input  1  synchronous active-low reset, sampled on the rclk rising edge.
- en  input  1  pop enable; when 0, no FIFO reads are issued.
- rempty  input  1  FIFO empty flag (read domain).
- rdata  input  DSIZE  FIFO read data; valid combinationally whenever rempty=0.
- rinc  output  1  FIFO pop strobe (combinational).
- flush  input  1  single-cycle request to emit the partial word.
- out_data  output  DSIZE*RATIO  packed word; lane 0 = oldest entry, in the LSBs.
- out_keep  output  RATIO  one bit per valid lane.
- out_last  output  1  set only on a word emitted by a flush.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- flush_done  output  1  one-cycle pulse when a flush completes.
- busy  output  1  cnt!=0 or flush_pend or out_valid.

Behaviour:

Internal state:
- asm: (RATIO-1)*DSIZE assembly register.
- cnt: lane counter, 0..RATIO-1.
- flush_pend: registered flush request.
- Output register: out_data, out_keep, out_last, out_valid.

Reset (rrst_n=0 at an rclk edge):
- cnt=0, asm=0, flush_pend=0, out_valid=0, out_data=0, out_keep=0, out_last=0, flush_done=0.
- rinc is forced 0 while rrst_n=0.
- Reset mid-word discards the partial word and any pending output.

Pop rule (combinational):
- out_free = !out_valid || out_ready.
- rinc = rrst_n && en && !rempty && !flush_pend && (cnt!=RATIO-1 || out_free).

On a pop with cnt<RATIO-1:
- asm lane[cnt] <= rdata; cnt <= cnt+1.

On a pop with cnt==RATIO-1 (out_free is guaranteed by the pop rule):
- out_data <= {rdata, asm lanes}; out_keep <= all ones; out_last <= 0; out_valid <= 1; cnt <= 0.
- out_valid rises the edge after the completing pop, i.e. 1-cycle latency.

Output handshake:
- A transfer occurs when out_valid && out_ready.
- On a transfer with no new word loaded that cycle: out_valid <= 0.
- A transfer and a new load in the same cycle give back-to-back words with no bubble.
- out_data, out_keep and out_last hold stable while out_valid && !out_ready.

Flush:
- flush=1 sets flush_pend at the next edge.
- A pop in the same cycle flush is asserted still occurs and belongs to the flushed data.
- A flush asserted while flush_pend=1 is merged (ignored).
- While flush_pend=1:
  - Pops are blocked.
  - When out_free and cnt>0: out_data <= asm lanes 0..cnt-1 with unused lanes zero; out_keep <= (1<<cnt)-1; out_last <= 1; out_valid <= 1; cnt <= 0; flush_pend <= 0; flush_done <= 1.
  - When cnt==0: flush_pend <= 0 and flush_done <= 1 with no output word, regardless of out_free.
- flush_done is high for exactly one cycle.

Other rules:
- en=0 blocks pops only; pending output and flush still complete.
- rempty toggling mid-word simply stalls assembly; no timeout.
- All counters wrap only through the explicit cnt<=0 paths.

Test Plan:
1. Reset: rrst_n=0 for 2 cycles with rempty=0, en=1 -> rinc=0 throughout, out_valid=0, busy=0; after release, rinc=1 on the first cycle.
2. Streaming: DSIZE=8, RATIO=4, FIFO holds 11,22,...,88, out_ready=1 -> out_data=0x44332211 then 0x88776655, keep=4'hF, last=0, out_valid rises the cycle after the 4th and 8th pop.
3. Backpressure: same data, out_ready=0 -> word 0x44332211 held stable; 55,66,77 are popped, then rinc=0 with rempty=0; raise out_ready -> 0x88776655 follows, no loss or duplication.
4. Partial flush: pop AA,BB,CC then pulse flush -> out_data=0x00CCBBAA, out_keep=4'b0111, out_last=1, flush_done pulse; rinc=0 while flush_pend=1.
5. Empty flush and flush-with-pop: flush with cnt=0 -> flush_done after 1 cycle, no out_valid. Flush in the same cycle as the 4th pop -> full word with keep=4'hF and last=0, then flush_done, no partial word.
6. Reset mid-word: pop 2 entries, assert rrst_n=0 for 1 cycle, then pop 4 entries 01..04 -> out_data=0x04030201; the pre-reset entries never appear.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read port, flush control and packed output stream of the packer
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
);
    logic en, rempty, rinc, flush, out_last, out_valid, out_ready, flush_done, busy;
    logic [DSIZE-1:0] rdata;
    logic [DSIZE*RATIO-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    modport master (
        input en, rempty, rdata, flush, out_ready,
        output rinc, out_data, out_keep, out_last, out_valid, flush_done, busy
    );
    modport slave (
        output en, rempty, rdata, flush, out_ready,
        input rinc, out_data, out_keep, out_last, out_valid, flush_done, busy
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs RATIO consecutive FIFO entries into one wide word, with partial-word flush
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input logic rclk,
    input logic rrst_n,
    fifo_rd_packer_if.master bus
);
    localparam int CW = $clog2(RATIO);
    logic [CW-1:0] cnt;
    logic [RATIO-2:0][DSIZE-1:0] asm_q;
    logic [RATIO-1:0][DSIZE-1:0] part_data;
    logic [RATIO-1:0] part_keep;
    logic [DSIZE*RATIO-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    logic flush_pend, out_free, last_lane, out_last, out_valid, flush_done;
    assign out_free = !out_valid || bus.out_ready;
    assign last_lane = cnt == CW'(RATIO - 1);
    // The completing pop is only allowed when the output register can take the word
    assign bus.rinc = rrst_n && bus.en && !bus.rempty && !flush_pend && (!last_lane || out_free);
    assign bus.out_data = out_data;
    assign bus.out_keep = out_keep;
    assign bus.out_last = out_last;
    assign bus.out_valid = out_valid;
    assign bus.flush_done = flush_done;
    assign bus.busy = (cnt != '0) || flush_pend || out_valid;
    always_comb begin
        part_data = '0;
        part_keep = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            part_data[i] = (i < int'(cnt)) ? asm_q[i] : '0;
            part_keep[i] = i < int'(cnt);
        end
    end
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            cnt <= '0;
            asm_q <= '0;
            flush_pend <= 1'b0;
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
            out_valid <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (out_valid && bus.out_ready) out_valid <= 1'b0;
            if (bus.rinc && !last_lane) begin
                asm_q[cnt] <= bus.rdata;
                cnt <= cnt + 1'b1;
            end
            if (bus.rinc && last_lane) begin
                out_data <= {bus.rdata, asm_q};
                out_keep <= '1;
                out_last <= 1'b0;
                out_valid <= 1'b1;
                cnt <= '0;
            end
            if (flush_pend) begin
                if (cnt == '0) begin
                    flush_pend <= 1'b0;
                    flush_done <= 1'b1;
                end else if (out_free) begin
                    out_data <= part_data;
                    out_keep <= part_keep;
                    out_last <= 1'b1;
                    out_valid <= 1'b1;
                    cnt <= '0;
                    flush_pend <= 1'b0;
                    flush_done <= 1'b1;
                end
            end else if (bus.flush) begin
                flush_pend <= 1'b1;
            end
        end
    end
endmodule
